// File: rtl/insn_encoder.sv
// RV32I encoder for the LUI/AUIPC/OP-IMM/OP subset, feeding a 2-entry output FIFO.
// Define ENCODER_CHECK_EN to enable the legality checks, the error flag and the error counter.
module insn_encoder (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    output logic [31:0] insn_data_o,
    output logic        insn_err_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [6:0]  OPC_LUI   = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
    localparam logic [6:0]  OPC_IMM   = 7'b0010011;
    localparam logic [6:0]  OPC_REG   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_U,
        FMT_I,
        FMT_SH,
        FMT_R,
        FMT_BAD
    } fmt_e;

    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] packed_word;
    logic [31:0] push_word;
    logic        push_err;
    logic        push;
    logic        pop;

    logic [31:0] head_word;
    logic        head_err;
    logic [31:0] tail_word;
    logic        tail_err;
    logic [1:0]  count;

    // Mnemonic decode: instruction format plus opcode/funct fields.
    always_comb begin
        fmt    = FMT_BAD;
        opcode = OPC_IMM;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        case (req_op_i)
            5'd0:  begin fmt = FMT_U;  opcode = OPC_LUI;   end
            5'd1:  begin fmt = FMT_U;  opcode = OPC_AUIPC; end
            5'd2:  begin fmt = FMT_I;  funct3 = 3'b000; end
            5'd3:  begin fmt = FMT_I;  funct3 = 3'b010; end
            5'd4:  begin fmt = FMT_I;  funct3 = 3'b011; end
            5'd5:  begin fmt = FMT_I;  funct3 = 3'b100; end
            5'd6:  begin fmt = FMT_I;  funct3 = 3'b110; end
            5'd7:  begin fmt = FMT_I;  funct3 = 3'b111; end
            5'd8:  begin fmt = FMT_SH; funct3 = 3'b001; end
            5'd9:  begin fmt = FMT_SH; funct3 = 3'b101; end
            5'd10: begin fmt = FMT_SH; funct3 = 3'b101; funct7 = 7'b0100000; end
            5'd11: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b000; end
            5'd12: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b000; funct7 = 7'b0100000; end
            5'd13: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b001; end
            5'd14: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b010; end
            5'd15: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b011; end
            5'd16: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b100; end
            5'd17: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b101; end
            5'd18: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b101; funct7 = 7'b0100000; end
            5'd19: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b110; end
            5'd20: begin fmt = FMT_R;  opcode = OPC_REG; funct3 = 3'b111; end
            default: fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        packed_word = NOP_WORD;
        case (fmt)
            FMT_U:  packed_word = {req_imm_i[31:12], req_rd_i, opcode};
            FMT_I:  packed_word = {req_imm_i[11:0], req_rs1_i, funct3, req_rd_i, opcode};
            FMT_SH: packed_word = {funct7, req_imm_i[4:0], req_rs1_i, funct3, req_rd_i, opcode};
            FMT_R:  packed_word = {funct7, req_rs2_i, req_rs1_i, funct3, req_rd_i, opcode};
            default: packed_word = NOP_WORD;
        endcase
    end

`ifdef ENCODER_CHECK_EN
    logic        illegal;
    logic [15:0] err_cnt;

    // I-type immediates must sign-extend from bit 11, so bits 31:11 are all equal.
    always_comb begin
        illegal = 1'b0;
        case (fmt)
            FMT_U:   illegal = |req_imm_i[11:0];
            FMT_I:   illegal = !((&req_imm_i[31:11]) || !(|req_imm_i[31:11]));
            FMT_SH:  illegal = |req_imm_i[31:5];
            FMT_R:   illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

    assign push_err = illegal;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt <= 16'h0000;
        end else if (push && push_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign push_err  = 1'b0;
    assign err_cnt_o = 16'h0000;
`endif

    assign push_word = push_err ? NOP_WORD : packed_word;

    assign req_ready_o  = (count != 2'd2);
    assign insn_valid_o = (count != 2'd0);
    assign insn_data_o  = head_word;
    assign insn_err_o   = head_err & insn_valid_o;
    assign push         = req_valid_i & req_ready_o;
    assign pop          = insn_valid_o & insn_ready_i;

    // The head is a dedicated register so insn_data_o keeps its last value once the FIFO drains.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_word <= 32'h0000_0000;
            head_err  <= 1'b0;
            tail_word <= 32'h0000_0000;
            tail_err  <= 1'b0;
            count     <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_word <= push_word;
                        head_err  <= push_err;
                        count     <= 2'd1;
                    end else begin
                        tail_word <= push_word;
                        tail_err  <= push_err;
                        count     <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_word <= tail_word;
                        head_err  <= tail_err;
                        count     <= 2'd1;
                    end else begin
                        count <= 2'd0;
                    end
                end
                2'b11: begin
                    head_word <= push_word;
                    head_err  <= push_err;
                end
                default: ;
            endcase
        end
    end

endmodule
